// File: rtl/seq_pkg.sv
// seq_pkg: constants shared by the sequence stepper and its tick generator.
package seq_pkg;

   // Width of the rate-select input (four tick rates).
   localparam int RATE_W = 2;

   // All segments off on an active-low display.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low 7-segment patterns (bit0=a ... bit6=g), indexed by digit.
   // Codes 10..15 are never produced by the decimal split and show blank.
   localparam logic [15:0][6:0] SEG_TABLE = {
      SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      return SEG_TABLE[digit];
   endfunction

endpackage

// File: rtl/rate_tick.sv
// rate_tick: clock-enable tick generator; one pulse every FPGA_FREQ >> rate cycles.
module rate_tick
   import seq_pkg::*;
#(
   parameter int FPGA_FREQ = 50_000_000
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              run,
   input  logic [RATE_W-1:0] rate,
   output logic              tick
);

   localparam int CNT_W = $clog2(FPGA_FREQ);

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_last;
   logic [RATE_W-1:0] rate_q;
   logic              primed;
   logic              rate_changed;

   // Terminal count for the selected rate; the pulse is suppressed in a rate-change cycle
   // and forced low while reset is asserted.
   // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
   always_comb begin
      cnt_last     = CNT_W'((FPGA_FREQ >> rate) - 1);
      rate_changed = primed && (rate != rate_q);
      tick         = nreset && run && !rate_changed && (cnt == cnt_last);
   end

   // Counter wraps at the terminal count; held at 0 while stopped or when the rate changes.
   // primed keeps the reset value of rate_q from looking like a rate change after release.
   // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt    <= '0;
         rate_q <= '0;
         primed <= 1'b0;
      end else begin
         rate_q <= rate;
         primed <= 1'b1;
         if (!run || rate_changed || (cnt == cnt_last)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sequence_stepper.sv
// sequence_stepper: steps through a constant table of values, automatically at a selectable
// rate or one entry per pushbutton press, and shows the selected value on two 7-seg digits.
module sequence_stepper
   import seq_pkg::*;
#(
   parameter int                     FPGA_FREQ = 50_000_000,
   parameter int                     DEPTH     = 8,
   parameter int                     WIDTH     = 4,
   parameter logic [DEPTH*WIDTH-1:0] SEQ       = 32'h752F_C963
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     run,
   input  logic                     up,
   input  logic [RATE_W-1:0]        rate,
   input  logic                     bounce,
   input  logic                     step,
   output logic                     muestreo,
   output logic [$clog2(DEPTH)-1:0] idx,
   output logic [WIDTH-1:0]         value,
   output logic [6:0]               hex0,
   output logic [6:0]               hex1,
   output logic                     at_end
);

   localparam int               IDX_W    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

   logic [1:0]       step_sync;
   logic             step_q;
   logic             step_edge;
   logic             dir;
   logic             fwd;
   logic             advance;
   logic [WIDTH-1:0] entry [DEPTH];
   logic [5:0]       value6;
   logic [3:0]       tens;
   logic [3:0]       units;

   rate_tick #(
      .FPGA_FREQ (FPGA_FREQ)
   ) u_rate_tick (
      .clk    (clk),
      .nreset (nreset),
      .run    (run),
      .rate   (rate),
      .tick   (muestreo)
   );

   // Two-flop synchroniser on the pushbutton, then a registered one-cycle rising-edge pulse.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         step_sync <= '0;
         step_q    <= 1'b0;
         step_edge <= 1'b0;
      end else begin
         step_sync <= {step_sync[0], step};
         step_q    <= step_sync[1];
         step_edge <= step_sync[1] & ~step_q;
      end
   end

   // Ticks drive the sequence while running; button presses only count while stopped.
   assign advance = run ? muestreo : step_edge;
   assign fwd     = up ^ dir;

   // Move idx one position per advance; wrap at the ends, or reverse direction in bounce mode.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         idx <= '0;
         dir <= 1'b0;
      end else begin
         if (!bounce) begin
            dir <= 1'b0;
         end
         if (advance) begin
            if (fwd) begin
               if (idx == IDX_LAST) begin
                  if (bounce) begin
                     dir <= ~dir;
                     idx <= IDX_LAST - IDX_W'(1);
                  end else begin
                     idx <= '0;
                  end
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end else begin
               if (idx == '0) begin
                  if (bounce) begin
                     dir <= ~dir;
                     idx <= IDX_W'(1);
                  end else begin
                     idx <= IDX_LAST;
                  end
               end else begin
                  idx <= idx - IDX_W'(1);
               end
            end
         end
      end
   end

   // Unpack the constant table so entry k is SEQ[k*WIDTH +: WIDTH].
   for (genvar k = 0; k < DEPTH; k++) begin : g_entry
      assign entry[k] = SEQ[k*WIDTH +: WIDTH];
   end

   // Select the value, split it into decimal digits and decode both displays.
   always_comb begin
      value  = entry[idx];
      value6 = 6'(value);
      tens   = 4'(value6 / 6'd10);
      units  = 4'(value6 % 6'd10);
      hex0   = seg_decode(units);
      hex1   = (value6 < 6'd10) ? SEG_BLANK : seg_decode(tens);
      at_end = (idx == '0) || (idx == IDX_LAST);
   end

endmodule

// File: tb/tb_sequence_stepper.sv
// tb_sequence_stepper: directed bench with an expected-advance scoreboard for sequence_stepper.
module tb_sequence_stepper;

   logic       clk;
   logic       nreset;
   logic       run;
   logic       up;
   logic [1:0] rate;
   logic       bounce;
   logic       step;
   logic       muestreo;
   logic [2:0] idx;
   logic [3:0] value;
   logic [6:0] hex0;
   logic [6:0] hex1;
   logic       at_end;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected advance: new index, negedges waited for it, ticks seen while waiting.
   typedef struct {
      int idx;
      int gap;
      int ticks;
   } exp_t;

   exp_t exp_q[$];

   int seq_vals [8]  = '{3, 6, 9, 12, 15, 2, 5, 7};
   int bseq     [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

   sequence_stepper #(
      .FPGA_FREQ (8)
   ) dut (
      .clk      (clk),
      .nreset   (nreset),
      .run      (run),
      .up       (up),
      .rate     (rate),
      .bounce   (bounce),
      .step     (step),
      .muestreo (muestreo),
      .idx      (idx),
      .value    (value),
      .hex0     (hex0),
      .hex1     (hex1),
      .at_end   (at_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] exp_seg(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         9:       return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Compare every display output against the expected index.
   task automatic check_display(input string tag, input int e_idx);
      int v;
      v = seq_vals[e_idx];
      check({tag, "_idx"},    32'(idx),    32'(e_idx));
      check({tag, "_value"},  32'(value),  32'(v));
      check({tag, "_hex0"},   32'(hex0),   32'(exp_seg(v % 10)));
      check({tag, "_hex1"},   32'(hex1),   (v < 10) ? 32'h7F : 32'(exp_seg(v / 10)));
      check({tag, "_at_end"}, 32'(at_end), (e_idx == 0 || e_idx == 7) ? 32'd1 : 32'd0);
   endtask

   // Wait on negedges until idx moves (bounded); n = negedges waited, ticks = pulses seen before the move.
   task automatic wait_adv(input int limit, output int n, output int ticks);
      logic [2:0] start;
      start = idx;
      n     = 0;
      ticks = 0;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (idx !== start) break;
         if (muestreo === 1'b1) ticks++;
      end
   endtask

   // Consume the scoreboard: wait for each advance, then pop and compare.
   task automatic drain(input string tag);
      exp_t e;
      int   n;
      int   t;
      while (exp_q.size() > 0) begin
         wait_adv(exp_q[0].gap + 4, n, t);
         e = exp_q.pop_front();
         check_display(tag, e.idx);
         check({tag, "_gap"},   32'(n), 32'(e.gap));
         check({tag, "_ticks"}, 32'(t), 32'(e.ticks));
      end
   endtask

   // One button press while stopped: no move for three edges, move on the fourth, then no more.
   task automatic step_press(input int e_idx);
      int n;
      int t;
      exp_q.push_back('{e_idx, 1, 0});
      step = 1'b1;
      wait_adv(3, n, t);
      check("step_latency_hold", 32'(n), 32'd3);
      drain("step");
      step = 1'b0;
      wait_adv(6, n, t);
      check("step_single", 32'(n), 32'd6);
   endtask

   initial begin
      int n;
      int t;

      nreset = 1'b1;
      run    = 1'b0;
      up     = 1'b1;
      rate   = 2'd0;
      bounce = 1'b0;
      step   = 1'b0;

      // Reset state, observed before any clock edge.
      #2 nreset = 1'b0;
      #1;
      check_display("reset", 0);
      check("reset_muestreo", 32'(muestreo), 32'd0);

      // Forward wrap at rate 0: one tick and one advance every 8 clocks.
      @(negedge clk);
      run    = 1'b1;
      nreset = 1'b1;
      for (int i = 1; i <= 8; i++) exp_q.push_back('{i % 8, 8, 1});
      drain("wrap_fwd");

      // Reverse at rate 3: the rate change swallows one cycle, then a tick every clock.
      up   = 1'b0;
      rate = 2'd3;
      exp_q.push_back('{7, 2, 1});
      exp_q.push_back('{6, 1, 0});
      exp_q.push_back('{5, 1, 0});
      drain("rev_fast");

      // Rate 3 -> 1: no tick in the change cycle, then one tick every 4 clocks.
      rate = 2'd1;
      exp_q.push_back('{4, 5, 1});
      exp_q.push_back('{3, 4, 1});
      drain("rate_change");

      // Reset mid-sequence discards any pending advance.
      #1 nreset = 1'b0;
      #1;
      check_display("reset_mid", 0);

      // Bounce mode from reset at rate 3.
      rate   = 2'd3;
      bounce = 1'b1;
      up     = 1'b1;
      run    = 1'b1;
      @(negedge clk);
      nreset = 1'b1;
      foreach (bseq[i]) exp_q.push_back('{bseq[i], 1, 0});
      drain("bounce");

      // Stopped: no ticks and no movement.
      run = 1'b0;
      #1 nreset = 1'b0;
      bounce = 1'b0;
      rate   = 2'd0;
      @(negedge clk);
      nreset = 1'b1;
      wait_adv(10, n, t);
      check("stopped_hold", 32'(n), 32'd10);
      check("stopped_ticks", 32'(t), 32'd0);

      // Single steps while stopped.
      step_press(1);
      step_press(2);
      step_press(3);

      // A press while running is ignored (run lasts 6 clocks, shorter than one tick period).
      run  = 1'b1;
      step = 1'b1;
      wait_adv(2, n, t);
      check("run_step_hold_a", 32'(n), 32'd2);
      step = 1'b0;
      wait_adv(4, n, t);
      check("run_step_hold_b", 32'(n), 32'd4);
      run = 1'b0;
      wait_adv(6, n, t);
      check("run_step_hold_c", 32'(n), 32'd6);
      check("run_step_idx", 32'(idx), 32'd3);

      step_press(4);
      step_press(5);

      // Asynchronous reset in the middle of a tick period at idx 5.
      run = 1'b1;
      wait_adv(3, n, t);
      check("midcount_hold", 32'(n), 32'd3);
      #2 nreset = 1'b0;
      #1;
      check_display("async_rst", 0);
      check("async_rst_muestreo", 32'(muestreo), 32'd0);
      @(negedge clk);
      nreset = 1'b1;
      exp_q.push_back('{1, 8, 1});
      drain("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sequence_stepper.md
SEQUENCE_STEPPER -- requirements
Module: sequence_stepper

Interface
REQ-001 Parameter FPGA_FREQ, default 50_000_000, clk cycles per second; SHALL be >= 8.
REQ-002 Parameter DEPTH, default 8, number of sequence entries; SHALL be 2..16.
REQ-003 Parameter WIDTH, default 4, bits per entry; SHALL be 1..6, so every value is 0..63.
REQ-004 Parameter SEQ, packed DEPTH*WIDTH bits, entry k at bits [k*WIDTH +: WIDTH]; default entries 0..7 = 3,6,9,12,15,2,5,7.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 nreset  in  1  asynchronous, active-low reset.
REQ-007 run  in  1  1 = advance automatically on each rate tick.
REQ-008 up  in  1  1 = forward (index increments), 0 = reverse.
REQ-009 rate  in  2  tick period = FPGA_FREQ >> rate cycles (1, 2, 4 or 8 Hz at nominal clock).
REQ-010 bounce  in  1  0 = wrap at the ends, 1 = ping-pong at the ends.
REQ-011 step  in  1  asynchronous pushbutton, active-high; single-steps while run=0.
REQ-012 muestreo  out  1  one-clk pulse on every rate tick.
REQ-013 idx  out  $clog2(DEPTH)  current sequence index.
REQ-014 value  out  WIDTH  SEQ entry selected by idx.
REQ-015 hex0  out  7  units digit of value, 7-segment, active-low, bit0=a ... bit6=g.
REQ-016 hex1  out  7  tens digit of value, same encoding.
REQ-017 at_end  out  1  1 when idx==0 or idx==DEPTH-1.

Function
REQ-018 Timing: all state SHALL change on posedge clk only. Clock muxing is forbidden; rate selection SHALL work through a clock-enable tick.
REQ-019 Tick counter: while run=1, the counter SHALL count 0..(FPGA_FREQ>>rate)-1 and assert muestreo for exactly the cycle in which it wraps.
REQ-020 While run=0, the tick counter SHALL be held at 0 and muestreo SHALL be 0.
REQ-021 A change of rate SHALL clear the tick counter on the next edge; no tick SHALL be issued in that cycle.
REQ-022 Step input: step SHALL pass through a 2-flop synchroniser plus an edge register; one rising edge SHALL produce exactly one advance.
REQ-023 Step latency: idx SHALL update on the 3rd posedge after step is first sampled high.
REQ-024 A step edge that occurs while run=1 SHALL be ignored.
REQ-025 Advance = (run & muestreo) | (!run & step_edge). idx SHALL change only on an advance, and by exactly one position.
REQ-026 Direction: an internal dir flag SHALL exist; effective direction = up XOR dir.
REQ-027 Wrap mode (bounce=0): forward from DEPTH-1 -> 0; reverse from 0 -> DEPTH-1; dir SHALL be held at 0.
REQ-028 Bounce mode (bounce=1), forward end: an advance at DEPTH-1 while moving forward SHALL toggle dir and move idx to DEPTH-2.
REQ-029 Bounce mode, reverse end: an advance at 0 while moving reverse SHALL toggle dir and move idx to 1.
REQ-030 bounce 1->0 SHALL clear dir on the next edge.
REQ-031 value, hex0, hex1 and at_end SHALL be combinational from idx; zero added latency.
REQ-032 hex1 SHALL be blank (all segments off, 7'h7F) when value < 10.

Reset
REQ-033 nreset low SHALL immediately set idx=0, dir=0, tick counter=0, synchroniser/edge flops=0 and muestreo=0.
REQ-034 While in reset the outputs SHALL be: value=SEQ[0]; hex0 and hex1 decoded from SEQ[0]; at_end=1.
REQ-035 Reset asserted mid-sequence or mid-tick SHALL discard any pending advance.
REQ-036 Release: the first tick SHALL occur FPGA_FREQ>>rate cycles after release with run=1.

Structure
REQ-037 Package seq_pkg SHALL hold the active-low digit-to-segment constant table and the RATE_W=2 constant.
REQ-038 Sub-module rate_tick (FPGA_FREQ parameter; inputs clk, nreset, run, rate; output tick) SHALL hold the counter of REQ-019..021.
REQ-039 Decimal split and segment decode SHALL be local combinational logic.

Verification
REQ-040 Wrap forward: FPGA_FREQ=8, rate=0, run=1, up=1, bounce=0 -> muestreo every 8 clk; value 3,6,9,12,15,2,5,7,3; hex1/hex0 show blank/3 then 1/2.
REQ-041 Reverse and rate change: from idx 0, up=0, rate=3 -> tick every clk; idx 7,6,5. Then rate->1 -> no tick next cycle, then one tick every 4 clk.
REQ-042 Bounce: bounce=1, up=1, rate=3 from reset -> idx 0..7, then 6,5,...,0, then 1; at_end high exactly at idx 0 and 7.
REQ-043 Step: run=0, three separate step pulses -> idx 1,2,3, each on the 3rd clk after sampling; a step pulse during run=1 -> no extra advance.
REQ-044 Async reset: drop nreset mid-count at idx 5 -> idx=0, hex0=3 (segments 7'b0110000), hex1=7'h7F with no clk edge; after release the first tick comes after 8 clk (rate=0).
